// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronizes raw GPIO pins, debounces each bit, and latches
// qualified rising/falling edges into sticky pending bits with a registered irq.
module gpio_in_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_pin,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] gpio_level,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0][CW-1:0]          cnt_r;
  logic [WIDTH-1:0][CW-1:0]          cnt_nxt_s;
  logic [WIDTH-1:0]                  level_r;
  logic [WIDTH-1:0]                  level_nxt_s;
  logic [WIDTH-1:0]                  ev_s;
  logic [WIDTH-1:0]                  pending_r;
  logic [WIDTH-1:0]                  pending_nxt_s;
  logic                              irq_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Multi-stage synchronizer; stage 0 samples the asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], gpio_pin};
    end
  end

  // Debounce next-state, edge qualification and pending next-state.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == level_r[i]) begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        level_nxt_s[i] = sync_s[i];
        cnt_nxt_s[i]   = {CW{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
    // A set on the same edge as clr wins because ev is OR-ed in last.
    ev_s          = (level_nxt_s & ~level_r & rise_en) | (~level_nxt_s & level_r & fall_en);
    pending_nxt_s = (pending_r & ~clr) | ev_s;
  end

  // Debounce, pending and interrupt state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      level_r   <= {WIDTH{1'b0}};
      pending_r <= {WIDTH{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      level_r   <= level_nxt_s;
      pending_r <= pending_nxt_s;
      irq_r     <= |(pending_r & irq_mask);
    end
  end

  assign gpio_level = level_r;
  assign pending    = pending_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture: expected values are queued when stimulus
// is driven and popped against DUT outputs sampled on the falling clock edge.
module tb_gpio_in_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_pin, rise_en, fall_en, irq_mask, clr;
  logic [7:0] level, pending;
  logic       irq;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;

  gpio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_pin   (gpio_pin),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_mask   (irq_mask),
    .clr        (clr),
    .gpio_level (level),
    .pending    (pending),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    sb_entry_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] lv, input logic [7:0] pd,
                           input logic ir);
    push({tag, "_level"}, lv);
    push({tag, "_pending"}, pd);
    push({tag, "_irq"}, {7'd0, ir});
    check(level);
    check(pending);
    check({7'd0, irq});
  endtask

  initial begin
    rst = 1'b1; gpio_pin = 8'h00; rise_en = 8'hFF; fall_en = 8'hFF;
    irq_mask = 8'hFF; clr = 8'h00;
    tick(3);
    check_all("reset", 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    tick(2);

    // Rising edge on bit 0: level/pending after edge 6, irq after edge 7.
    gpio_pin = 8'h01;
    tick(5);
    check_all("rise_e5", 8'h00, 8'h00, 1'b0);
    tick(1);
    check_all("rise_e6", 8'h01, 8'h01, 1'b0);
    tick(1);
    check_all("rise_e7", 8'h01, 8'h01, 1'b1);

    // Single-cycle clear: pending drops at edge k, irq at edge k+1.
    clr = 8'h01;
    tick(1);
    clr = 8'h00;
    check_all("clr_k", 8'h01, 8'h00, 1'b1);
    tick(1);
    check_all("clr_k1", 8'h01, 8'h00, 1'b0);

    // Three-cycle glitch on bit 2 is filtered out.
    gpio_pin = 8'h05;
    tick(3);
    gpio_pin = 8'h01;
    tick(8);
    check_all("glitch", 8'h01, 8'h00, 1'b0);

    // Event on bit 3 coincides with clr of bit 3: set wins.
    gpio_pin = 8'h09;
    tick(5);
    clr = 8'h08;
    tick(1);
    clr = 8'h00;
    check_all("setclr_e6", 8'h09, 8'h08, 1'b0);
    tick(1);
    check_all("setclr_e7", 8'h09, 8'h08, 1'b1);
    clr = 8'h08;
    tick(1);
    clr = 8'h00;
    tick(1);
    check_all("setclr_clr", 8'h09, 8'h00, 1'b0);

    // Bit 7 rise-only, masked: pending latches, irq stays low until unmasked.
    fall_en = 8'h00; rise_en = 8'h80; irq_mask = 8'h00;
    gpio_pin = 8'h89;
    tick(6);
    check_all("b7_rise", 8'h89, 8'h80, 1'b0);
    gpio_pin = 8'h09;
    tick(6);
    check_all("b7_fall", 8'h09, 8'h80, 1'b0);
    irq_mask = 8'h80;
    tick(1);
    check_all("b7_unmask", 8'h09, 8'h80, 1'b1);

    // Pins held high through reset release raise rise events after normal latency.
    rise_en = 8'hFF; irq_mask = 8'hFF;
    rst = 1'b1;
    gpio_pin = 8'hA5;
    #1;
    check_all("rst_async", 8'h00, 8'h00, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check_all("held_e5", 8'h00, 8'h00, 1'b0);
    tick(1);
    check_all("held_e6", 8'hA5, 8'hA5, 1'b0);
    tick(1);
    check_all("held_e7", 8'hA5, 8'hA5, 1'b1);

    // Reset mid-debounce clears everything at once and leaves no event behind.
    gpio_pin = 8'h5A;
    tick(4);
    rst = 1'b1;
    #1;
    check_all("rst_mid", 8'h00, 8'h00, 1'b0);
    gpio_pin = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(10);
    check_all("rst_after", 8'h00, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
